// File: rtl/core_pkg.sv
// Shared definitions for the EX-stage branch logic.
//   - funct3 encodings of the conditional branch compares
//   - resolver FSM state type
package core_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } resolver_state_e;

endpackage

// File: rtl/branch_cond_unit.sv
// Branch condition evaluator (purely combinational).
// Ports:
//   rs1_i, rs2_i : operands
//   funct3_i     : compare select (EQ/NE/LT/GE/LTU/GEU)
//   cond_o       : compare result; the unused encodings 010/011 give 0
module branch_cond_unit
  import core_pkg::*;
(
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [2:0]  funct3_i,
  output logic        cond_o
);

  always_comb begin
    cond_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond_o = (rs1_i == rs2_i);
      F3_BNE:  cond_o = (rs1_i != rs2_i);
      F3_BLT:  cond_o = ($signed(rs1_i) <  $signed(rs2_i));
      F3_BGE:  cond_o = ($signed(rs1_i) >= $signed(rs2_i));
      F3_BLTU: cond_o = (rs1_i <  rs2_i);
      F3_BGEU: cond_o = (rs1_i >= rs2_i);
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolver, companion of the gshare predictor in IF.
// Resolves conditional/unconditional/indirect jumps, checks the IF
// prediction, drives the predictor update, issues a registered one-cycle
// redirect and a FLUSH_CYCLES-long flush of younger stages, and keeps
// saturating branch / mispredict counters.
//
// Handshake: an EX instruction fires when valid_in && ready_in. A valid
// instruction without ready_in is stalled and has no effect; it is simply
// re-evaluated every cycle until it fires. Fires arriving while a flush is
// in progress are wrong-path and are squashed.
//
// Ports:
//   clk, reset (async, active-low)
//   valid_in, ready_in           : EX handshake
//   PC_EX, IM_EX, rs1_EX, rs2_EX : instruction operands
//   funct3_EX                    : branch condition select
//   jump_ena_EX/alw/ind/pred     : jump kind and IF prediction
//   cnt_clr                      : synchronous counter clear
//   upd_ena, jump_taken_EX, mispred_EX : combinational results
//   redirect, redirect_addr, flush     : registered fetch control
//   branch_cnt, mispred_cnt            : saturating counters
//   state_dbg                          : current FSM state
module branch_resolver
  import core_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             ready_in,
  input  logic [31:0]      PC_EX,
  input  logic [31:0]      IM_EX,
  input  logic [31:0]      rs1_EX,
  input  logic [31:0]      rs2_EX,
  input  logic [2:0]       funct3_EX,
  input  logic             jump_ena_EX,
  input  logic             jump_alw_EX,
  input  logic             jump_ind_EX,
  input  logic             jump_pred_EX,
  input  logic             cnt_clr,
  output logic             upd_ena,
  output logic             jump_taken_EX,
  output logic             mispred_EX,
  output logic             redirect,
  output logic [31:0]      redirect_addr,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output resolver_state_e  state_dbg
);

  localparam int unsigned FCNT_W = $clog2(FLUSH_CYCLES + 1);

  resolver_state_e   state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              redirect_q, redirect_d;
  logic              flush_q, flush_d;
  logic [31:0]       addr_q, addr_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [CNT_W-1:0]  mcnt_q, mcnt_d;

  logic        cond;
  logic        fire;
  logic        live;
  logic [31:0] target;
  logic [31:0] correct_addr;

  branch_cond_unit u_cond (
    .rs1_i    (rs1_EX),
    .rs2_i    (rs2_EX),
    .funct3_i (funct3_EX),
    .cond_o   (cond)
  );

  assign fire = valid_in && ready_in;
  assign live = fire && (state_q == IDLE);

  assign jump_taken_EX = jump_ena_EX && (jump_alw_EX || cond);

  // JALR clears bit 0 of the computed address.
  assign target       = jump_ind_EX ? ((rs1_EX + IM_EX) & 32'hFFFF_FFFE)
                                    : (PC_EX + IM_EX);
  assign correct_addr = jump_taken_EX ? target : (PC_EX + 32'd4);

  // Indirect jumps are never predicted, so a predicted-taken JALR is treated
  // as wrong; a predicted-taken direct target is always exact.
  assign mispred_EX = live && jump_ena_EX &&
                      ((jump_taken_EX != jump_pred_EX) ||
                       (jump_pred_EX && jump_ind_EX));

  assign upd_ena = live && jump_ena_EX && !jump_alw_EX;

  // Redirect/flush FSM
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    redirect_d = 1'b0;
    flush_d    = flush_q;
    addr_d     = addr_q;
    case (state_q)
      IDLE: begin
        flush_d = 1'b0;
        if (mispred_EX) begin
          redirect_d = 1'b1;
          addr_d     = correct_addr;
          flush_d    = 1'b1;
          fcnt_d     = FCNT_W'(1);
          state_d    = FLUSH;
        end
      end
      FLUSH: begin
        if (fcnt_q == FCNT_W'(FLUSH_CYCLES)) begin
          flush_d = 1'b0;
          fcnt_d  = '0;
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
        flush_d = 1'b0;
      end
    endcase
  end

  // Saturating counters; clear wins over a same-cycle increment.
  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (cnt_clr) begin
      bcnt_d = '0;
      mcnt_d = '0;
    end else begin
      if (live && jump_ena_EX && (bcnt_q != {CNT_W{1'b1}}))
        bcnt_d = bcnt_q + CNT_W'(1);
      if (mispred_EX && (mcnt_q != {CNT_W{1'b1}}))
        mcnt_d = mcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fcnt_q     <= '0;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      addr_q     <= '0;
      bcnt_q     <= '0;
      mcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
      addr_q     <= addr_d;
      bcnt_q     <= bcnt_d;
      mcnt_q     <= mcnt_d;
    end
  end

  assign redirect      = redirect_q;
  assign redirect_addr = addr_q;
  assign flush         = flush_q;
  assign branch_cnt    = bcnt_q;
  assign mispred_cnt   = mcnt_q;
  assign state_dbg     = state_q;

endmodule
